seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised, handshaked execute unit; successor to the combinational 32-bit ALU.
//  Keeps the ten integer ops and their 4-bit encodings, and adds iterative multiply/divide.
//  Latency is 1 cycle for basic ops and XLEN+1 cycles for mul/div.
//  Sits between decode/register-read and writeback in the CPU datapath.
// PARAMETERS
//  XLEN  32  operand/result width; power of two, >= 8
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operands/op offered
//  in_ready   out  1     unit can accept; high only in IDLE
//  ALU_op     in   4     opcode, sampled on accept
//  in0        in   XLEN  operand A (dividend/multiplicand)
//  in1        in   XLEN  operand B (divisor/multiplier/shift amount)
//  flush      in   1     abort in-flight op
//  out_valid  out  1     result/zero_flag valid; held until out_ready
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  registered result
//  zero_flag  out  1     registered (result == 0)
// BEHAVIOUR
//  Opcodes:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLTU, 6 SLT, 7 SLL, 8 SRL, 9 SRA
//   A MUL (low XLEN), B MULHU (high XLEN, unsigned), C DIV, D DIVU, E REM, F REMU
//  Accept: in_valid && in_ready. in0, in1 and ALU_op are captured; inputs are ignored afterwards.
//  FSM:
//   IDLE -accept basic op-> DONE
//   IDLE -accept A..F-> BUSY; cnt is loaded with XLEN-1
//   BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle
//   BUSY: cnt==0 -> DONE; sign fix-up is applied on that same edge
//   DONE: out_valid=1; out_ready -> IDLE
//  Latency:
//   basic op: out_valid on the edge after accept
//   A..F: out_valid exactly XLEN+1 edges after accept
//   results with out_ready tied high: one result per 2 cycles (basic), per XLEN+2 cycles (mul/div)
//  Widths and arithmetic:
//   add/sub/mul wrap modulo 2^XLEN
//   shifts use in1[$clog2(XLEN)-1:0]
//   SLT/SLTU produce 0 or 1, zero-extended
//   MULHU uses a 2*XLEN-bit accumulator
//  Signed div/rem: magnitudes are divided unsigned, then the sign is fixed.
//   quotient is negative iff the operand signs differ
//   remainder takes the sign of the dividend
//  Boundaries (RISC-V semantics):
//   divide by 0: DIV/DIVU -> all ones; REM/REMU -> in0
//   DIV overflow (in0 = -2^(XLEN-1), in1 = -1): quotient = in0, REM = 0
//   zero-divisor and overflow cases still take the full XLEN+1 cycles (fixed latency)
//   out_valid held and out_ready low: result/zero_flag stay stable, in_ready stays 0
//  flush:
//   in any state -> IDLE next edge; out_valid=0 next cycle; result is discarded
//   flush wins over a same-cycle accept or out_ready
//  rst: state=IDLE, out_valid=0, result=0, zero_flag=1, cnt=0, internal accumulators=0.
//   Mid-operation it behaves as flush. in_ready=1 on the first cycle after rst deasserts.
// CONFIGURATION
//  SEQ_ALU_DIV_EN
//   defined: opcodes C..F use the iterative divider described above
//   undefined: divider logic is not built; C..F are treated as basic ops
//    out_valid 1 cycle after accept; result=0, zero_flag=1
//    A/B multiply behaviour is unchanged
// TESTING
//  1. ADD 0x7FFFFFFF + 1 (XLEN=32) -> out_valid one edge later; result 0x80000000, zero_flag 0.
//  2. SUB 5-5 -> result 0, zero_flag 1. SRA 0x80000000 by 0x21 -> 0xC0000000 (shift amount 1).
//  3. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE at edge 33; MULHU same operands -> 0x00000001.
//  4. DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1; DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9.
//  5. DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0; both at edge 33.
//  6. Accept DIVU, flush at cycle 10 -> IDLE, no out_valid.
//     Then hold out_ready=0 for 5 cycles after an ADD: result stable, in_ready 0.
//     Repeat without SEQ_ALU_DIV_EN: DIV -> result 0 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Handshaked sequential execute unit. Ten single-cycle integer ops
//             plus an iterative shift-add multiplier (MUL / MULHU) and an
//             optional restoring divider (DIV / DIVU / REM / REMU).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN       operand / result width (power of two, >= 8)
//  Configuration macro
//    SEQ_ALU_DIV_EN  defined   : opcodes C..F run on the iterative divider
//                    undefined : no divider hardware; C..F complete in one
//                                cycle with result 0 / zero_flag 1
//  Ports
//    clk        in   1     clock, rising edge
//    rst        in   1     synchronous active-high reset
//    in_valid   in   1     operands / opcode offered
//    in_ready   out  1     unit can accept (IDLE only)
//    ALU_op     in   4     opcode, captured on accept
//    in0        in   XLEN  operand A (dividend / multiplicand)
//    in1        in   XLEN  operand B (divisor / multiplier / shift amount)
//    flush      in   1     abort any in-flight operation
//    out_valid  out  1     result / zero_flag valid, held until out_ready
//    out_ready  in   1     consumer takes the result
//    result     out  XLEN  registered result
//    zero_flag  out  1     registered (result == 0)
// ============================================================================
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_op,
    input  logic [XLEN-1:0] in0,
    input  logic [XLEN-1:0] in1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag
);

    localparam int CW = $clog2(XLEN);

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_AND   = 4'h2;
    localparam logic [3:0] c_OP_OR    = 4'h3;
    localparam logic [3:0] c_OP_XOR   = 4'h4;
    localparam logic [3:0] c_OP_SLTU  = 4'h5;
    localparam logic [3:0] c_OP_SLT   = 4'h6;
    localparam logic [3:0] c_OP_SLL   = 4'h7;
    localparam logic [3:0] c_OP_SRL   = 4'h8;
    localparam logic [3:0] c_OP_SRA   = 4'h9;
    localparam logic [3:0] c_OP_MUL   = 4'hA;
    localparam logic [3:0] c_OP_MULHU = 4'hB;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] c_OP_DIV   = 4'hC;
    localparam logic [3:0] c_OP_DIVU  = 4'hD;
    localparam logic [3:0] c_OP_REM   = 4'hE;
    localparam logic [3:0] c_OP_REMU  = 4'hF;
`endif

    localparam logic [CW-1:0] c_CNT_LOAD = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;
    logic                r_zero;

    logic                w_iter_op;
    logic [CW-1:0]       w_shamt;
    logic [XLEN-1:0]     w_basic;
    logic [2*XLEN-1:0]   w_acc_load;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_nxt;
    logic [2*XLEN-1:0]   w_step;
    logic [XLEN-1:0]     w_final;

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero_flag = r_zero;

`ifdef SEQ_ALU_DIV_EN
    assign w_iter_op = (ALU_op >= c_OP_MUL);
`else
    assign w_iter_op = (ALU_op == c_OP_MUL) || (ALU_op == c_OP_MULHU);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_nxt = w_iter_op ? S_BUSY : S_DONE;
                S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle operations, evaluated straight from the inputs at accept
    // ------------------------------------------------------------------
    assign w_shamt = in1[CW-1:0];

    always_comb begin
        w_basic = '0;
        case (ALU_op)
            c_OP_ADD:  w_basic = in0 + in1;
            c_OP_SUB:  w_basic = in0 - in1;
            c_OP_AND:  w_basic = in0 & in1;
            c_OP_OR:   w_basic = in0 | in1;
            c_OP_XOR:  w_basic = in0 ^ in1;
            c_OP_SLTU: w_basic = {{(XLEN-1){1'b0}}, (in0 < in1)};
            c_OP_SLT:  w_basic = {{(XLEN-1){1'b0}}, ($signed(in0) < $signed(in1))};
            c_OP_SLL:  w_basic = in0 << w_shamt;
            c_OP_SRL:  w_basic = in0 >> w_shamt;
            c_OP_SRA:  w_basic = $unsigned($signed(in0) >>> w_shamt);
            // Iterative ops and (without the divider) C..F yield 0 here.
            default:   w_basic = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier: accumulator = {partial product, multiplier}.
    // The LSB selects whether the multiplicand is added to the upper half;
    // the carry is kept by shifting the (XLEN+1)-bit sum back in.
    // ------------------------------------------------------------------
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + ({(XLEN+1){r_acc[0]}} & {1'b0, r_a});
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

`ifdef SEQ_ALU_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divider on magnitudes: accumulator = {remainder, dividend};
    // quotient bits shift into the low end. Signs are restored on the
    // final step.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   r_b;
    logic              w_ld_signed;
    logic [XLEN-1:0]   w_in0_mag;
    logic              w_signed_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_b_zero;
    logic [XLEN-1:0]   w_dvsr;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_ld_signed  = (ALU_op == c_OP_DIV) || (ALU_op == c_OP_REM);
    assign w_in0_mag    = (w_ld_signed && in0[XLEN-1]) ? (-in0) : in0;

    assign w_signed_div = (r_op == c_OP_DIV) || (r_op == c_OP_REM);
    assign w_a_neg      = w_signed_div & r_a[XLEN-1];
    assign w_b_neg      = w_signed_div & r_b[XLEN-1];
    assign w_b_zero     = (r_b == '0);
    assign w_dvsr       = w_b_neg ? (-r_b) : r_b;

    // The running remainder is always below the divisor, so one extra bit
    // is enough to tell a borrow from a valid difference. A zero divisor
    // breaks that bound, but its result is overridden below.
    assign w_div_trial  = r_acc[2*XLEN-1:XLEN-1] - {1'b0, w_dvsr};
    assign w_div_nxt    = w_div_trial[XLEN]
                        ? {r_acc[2*XLEN-2:0], 1'b0}
                        : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_quo = w_div_nxt[XLEN-1:0];
    assign w_rem = w_div_nxt[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= '0;
        end else if (!flush && (r_state == S_IDLE) && in_valid) begin
            r_b <= in1;
        end
    end
`endif

    always_comb begin
        w_acc_load = {{XLEN{1'b0}}, in1};
`ifdef SEQ_ALU_DIV_EN
        if (ALU_op >= c_OP_DIV) w_acc_load = {{XLEN{1'b0}}, w_in0_mag};
`endif
    end

    always_comb begin
        w_step = w_mul_nxt;
`ifdef SEQ_ALU_DIV_EN
        if (r_op >= c_OP_DIV) w_step = w_div_nxt;
`endif
    end

    // Result selection / sign fix-up on the last iteration.
    // Signed overflow (-2^(XLEN-1) / -1) needs no special case: the
    // magnitude quotient is 2^(XLEN-1), which already reads back as in0.
    always_comb begin
        w_final = w_step[XLEN-1:0];
        case (r_op)
            c_OP_MULHU: w_final = w_step[2*XLEN-1:XLEN];
`ifdef SEQ_ALU_DIV_EN
            c_OP_DIV:   w_final = w_b_zero ? '1 : ((w_a_neg ^ w_b_neg) ? (-w_quo) : w_quo);
            c_OP_DIVU:  w_final = w_b_zero ? '1 : w_quo;
            c_OP_REM:   w_final = w_b_zero ? r_a : (w_a_neg ? (-w_rem) : w_rem);
            c_OP_REMU:  w_final = w_b_zero ? r_a : w_rem;
`endif
            default:    w_final = w_step[XLEN-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. A flush leaves the result untouched; the FSM
    // alone discards it by never raising out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= ALU_op;
                        r_a  <= in0;
                        if (w_iter_op) begin
                            r_cnt <= c_CNT_LOAD;
                            r_acc <= w_acc_load;
                        end else begin
                            r_result <= w_basic;
                            r_zero   <= (w_basic == '0);
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_step;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
